blinky_sprite_renderer: RTL and testbench
=========================================

# blinky_sprite_renderer

Drives the ghost sprite ("Blinky") in the video pipeline. It patrols a rectangular path one pixel per frame, toggles the two-frame walk animation, and generates the bitmap row/column address from the beam position. It feeds the downstream combinational ghost bitmap ROM with `{direction, anim_state, bmp_y, bmp_x}` and registers the returned bit as the sprite pixel for the colour mixer.

## Interface
- `X_MIN`, default 16: left edge of the patrol rectangle (sprite top-left x).
- `X_MAX`, default 200: right edge of the patrol rectangle.
- `Y_MIN`, default 16: top edge of the patrol rectangle.
- `Y_MAX`, default 180: bottom edge of the patrol rectangle.
- `FRAME_DIV`, default 8: frame ticks per animation toggle, at least 1.
- `clk` in 1: pixel clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `hpos` in 9: beam x from the sync generator.
- `vpos` in 9: beam y from the sync generator.
- `display_on` in 1: visible-area flag.
- `vsync` in 1: vertical sync. Its rising edge is the frame tick.
- `enable` in 1: 1 = move and animate, 0 = freeze position and animation.
- `bmp_bit` in 1: bitmap ROM output for the current address (combinational return).
- `anim_state` out 1: animation frame select to the ROM.
- `direction` out 2: facing to the ROM. 0 = right, 1 = down, 2 = left, 3 = up.
- `bmp_y` out 4: bitmap row to the ROM.
- `bmp_x` out 4: bitmap column to the ROM.
- `ghost_x` out 9: current sprite top-left x.
- `ghost_y` out 9: current sprite top-left y.
- `pixel` out 1: sprite pixel, aligned 2 cycles after `hpos`/`vpos`.

## Operation
- **Tick detection**
  - `vsync` is registered once.
  - `tick = vsync & ~vsync_q`, a 1-cycle pulse.
- **Movement FSM.** States are RIGHT, DOWN, LEFT, UP. `direction` equals the state encoding.
- **On tick with `enable=1`:**
  - RIGHT: if `ghost_x==X_MAX`, go to DOWN and do not move; else `ghost_x+1`.
  - DOWN: if `ghost_y==Y_MAX`, go to LEFT; else `ghost_y+1`.
  - LEFT: if `ghost_x==X_MIN`, go to UP; else `ghost_x-1`.
  - UP: if `ghost_y==Y_MIN`, go to RIGHT; else `ghost_y-1`.
  - A turn tick never moves. One lap is `2*(X_MAX-X_MIN)+2*(Y_MAX-Y_MIN)+4` ticks.
- **Animation**
  - `frame_cnt` counts ticks while `enable=1`.
  - When `frame_cnt==FRAME_DIV-1` on a tick, `frame_cnt` goes to 0 and `anim_state` toggles.
- **`enable=0`:** ticks are ignored; FSM, position, `frame_cnt` and `anim_state` hold. Rendering continues.
- **Window test**
  - Compute `dx=hpos-ghost_x` and `dy=vpos-ghost_y` in 10 bits, so there is no 9-bit wraparound.
  - `in_win = display_on & (hpos>=ghost_x) & (dx<16) & (vpos>=ghost_y) & (dy<16)`.
- **Pipeline stage 1 (registered):**
  - `bmp_x<=dx[3:0]` and `bmp_y<=dy[3:0]` when `in_win`, else 0.
  - `win_q<=in_win`.
- **Pipeline stage 2 (registered):** `pixel<=win_q & bmp_bit`.

## Timing
- **Reset values while `reset_n=0`:** outputs and state take these values at once.
  - `ghost_x=X_MIN`, `ghost_y=Y_MIN`, state RIGHT, `direction=0`.
  - `anim_state=0`, `frame_cnt=0`, `vsync_q=0`.
  - `bmp_x=0`, `bmp_y=0`, `win_q=0`, `pixel=0`.
- **Release of `reset_n`:** the first clock edge after release is ordinary.
  - If `vsync` is already high, that edge registers it without producing a tick.
- **Position/FSM update:** `ghost_x`, `ghost_y`, `direction` and `anim_state` update on the clock edge where `tick=1`. That is 1 cycle after the `vsync` rising edge is sampled.
- **Tick during the visible area:** the new position applies to the window test from the next cycle. No hold-off is applied.
- **Pixel latency:** 2 clocks from `hpos`/`vpos` to `pixel`. `bmp_*` lags the beam by 1 clock.
- **Reset mid-frame:** the block returns to reset values. Movement resumes at the next tick after release.
- **Degenerate rectangle:** with `X_MIN==X_MAX`, RIGHT turns to DOWN on every RIGHT tick (no x motion), and LEFT behaves the same way.

## Test plan
- **Reset values:** assert `reset_n=0` mid-run -> `ghost_x=16`, `ghost_y=16`, `direction=0`, `anim_state=0`, `pixel=0` with no clock edge needed.
- **Rightward motion:** 3 `vsync` pulses with `enable=1` -> `ghost_x=19`, `ghost_y=16`, `direction=0`. Each change occurs 1 cycle after its rising edge.
- **Corner turn:** preset via `X_MAX=18`, then 3 ticks -> `ghost_x=18`, `direction=1`, `ghost_y=16`. The next tick gives `ghost_y=17`.
- **Animation and freeze:** with `FRAME_DIV=8`, 8 ticks -> `anim_state` 0→1. With 8 more ticks under `enable=0`, `anim_state` and `ghost_x` are unchanged.
- **Window and pixel latency:** ghost at (16,16), `bmp_bit` tied to 1, sweep `hpos` 14..33 on `vpos=20`.
  - `bmp_x` reads 0..15 and `bmp_y=4` one cycle after `hpos` 16..31.
  - `pixel=1` exactly 2 cycles after `hpos` 16..31, else 0.
  - `display_on=0` -> `pixel` stays 0.
- **Full lap:** `X_MAX=20`, `Y_MAX=20`, 20 ticks -> back at (16,16) with `direction=0`.

Source files
------------

// File: rtl/blinky_sprite_renderer.sv
// Ghost sprite: patrols a rectangle one pixel per frame tick, toggles walk animation, addresses the bitmap ROM.
// Latency: bmp_* 1 clock after hpos/vpos, pixel 2 clocks; no backpressure, free-running pixel pipeline.
module blinky_sprite_renderer #(
  parameter int X_MIN     = 16,
  parameter int X_MAX     = 200,
  parameter int Y_MIN     = 16,
  parameter int Y_MAX     = 180,
  parameter int FRAME_DIV = 8
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [8:0] i_hpos,
  input  logic [8:0] i_vpos,
  input  logic       i_display_on,
  input  logic       i_vsync,
  input  logic       i_enable,
  input  logic       i_bmp_bit,
  output logic       o_anim_state,
  output logic [1:0] o_direction,
  output logic [3:0] o_bmp_y,
  output logic [3:0] o_bmp_x,
  output logic [8:0] o_ghost_x,
  output logic [8:0] o_ghost_y,
  output logic       o_pixel
);

  localparam int          CW      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] FD_LAST = CW'(FRAME_DIV - 1);
  localparam logic [8:0]  XMIN9   = 9'(X_MIN);
  localparam logic [8:0]  XMAX9   = 9'(X_MAX);
  localparam logic [8:0]  YMIN9   = 9'(Y_MIN);
  localparam logic [8:0]  YMAX9   = 9'(Y_MAX);

  typedef enum logic [1:0] {
    S_RIGHT = 2'd0,
    S_DOWN  = 2'd1,
    S_LEFT  = 2'd2,
    S_UP    = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [8:0]    r_gx, r_gy, w_gx_nxt, w_gy_nxt;
  logic [CW-1:0] r_frame_cnt, w_frame_cnt_nxt;
  logic          r_anim, w_anim_nxt;
  logic          r_vsync_q, r_armed;
  logic          w_tick, w_adv;
  logic [9:0]    w_dx, w_dy;
  logic          w_in_win;
  logic [3:0]    r_bmp_x, r_bmp_y;
  logic          r_win_q, r_pixel;

  // r_armed keeps the first edge after reset from seeing a vsync that was already high as a rising edge
  assign w_tick = i_vsync & ~r_vsync_q & r_armed;
  assign w_adv  = w_tick & i_enable;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_RIGHT;
      r_gx        <= XMIN9;
      r_gy        <= YMIN9;
      r_frame_cnt <= '0;
      r_anim      <= 1'b0;
      r_vsync_q   <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gx        <= w_gx_nxt;
      r_gy        <= w_gy_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_anim      <= w_anim_nxt;
      r_vsync_q   <= i_vsync;
      r_armed     <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_gx_nxt        = r_gx;
    w_gy_nxt        = r_gy;
    w_frame_cnt_nxt = r_frame_cnt;
    w_anim_nxt      = r_anim;
    if (w_adv) begin
      // a turn tick changes direction only; the move happens on the following tick
      case (r_state)
        S_RIGHT: if (r_gx == XMAX9) w_state_nxt = S_DOWN;  else w_gx_nxt = r_gx + 9'd1;
        S_DOWN:  if (r_gy == YMAX9) w_state_nxt = S_LEFT;  else w_gy_nxt = r_gy + 9'd1;
        S_LEFT:  if (r_gx == XMIN9) w_state_nxt = S_UP;    else w_gx_nxt = r_gx - 9'd1;
        default: if (r_gy == YMIN9) w_state_nxt = S_RIGHT; else w_gy_nxt = r_gy - 9'd1;
      endcase
      if (r_frame_cnt == FD_LAST) begin
        w_frame_cnt_nxt = '0;
        w_anim_nxt      = ~r_anim;
      end else begin
        w_frame_cnt_nxt = r_frame_cnt + 1'b1;
      end
    end
  end

  assign w_dx     = {1'b0, i_hpos} - {1'b0, r_gx};
  assign w_dy     = {1'b0, i_vpos} - {1'b0, r_gy};
  assign w_in_win = i_display_on & (i_hpos >= r_gx) & (w_dx < 10'd16)
                  & (i_vpos >= r_gy) & (w_dy < 10'd16);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bmp_x <= 4'd0;
      r_bmp_y <= 4'd0;
      r_win_q <= 1'b0;
      r_pixel <= 1'b0;
    end else begin
      r_bmp_x <= w_in_win ? w_dx[3:0] : 4'd0;
      r_bmp_y <= w_in_win ? w_dy[3:0] : 4'd0;
      r_win_q <= w_in_win;
      r_pixel <= r_win_q & i_bmp_bit;
    end
  end

  assign o_anim_state = r_anim;
  assign o_direction  = r_state;
  assign o_bmp_x      = r_bmp_x;
  assign o_bmp_y      = r_bmp_y;
  assign o_ghost_x    = r_gx;
  assign o_ghost_y    = r_gy;
  assign o_pixel      = r_pixel;

endmodule

// File: tb/tb_blinky_sprite_renderer.sv
// Scoreboarded bench: three renderers (default, narrow X_MAX=18, small 20x20 rectangle) share one beam/vsync.
module tb_blinky_sprite_renderer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       enable = 1'b0;
  logic       display_on = 1'b0;
  logic       bmp_bit = 1'b0;
  logic [8:0] hpos = '0;
  logic [8:0] vpos = '0;

  logic       a_anim, b_anim, c_anim, a_pix, b_pix, c_pix;
  logic [1:0] a_dir, b_dir, c_dir;
  logic [3:0] a_bx, a_by, b_bx, b_by, c_bx, c_by;
  logic [8:0] a_gx, a_gy, b_gx, b_gy, c_gx, c_gy;

  blinky_sprite_renderer dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_hpos(hpos), .i_vpos(vpos), .i_display_on(display_on),
    .i_vsync(vsync), .i_enable(enable), .i_bmp_bit(bmp_bit), .o_anim_state(a_anim),
    .o_direction(a_dir), .o_bmp_y(a_by), .o_bmp_x(a_bx), .o_ghost_x(a_gx), .o_ghost_y(a_gy),
    .o_pixel(a_pix));

  blinky_sprite_renderer #(.X_MAX(18), .Y_MAX(20)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_hpos(hpos), .i_vpos(vpos), .i_display_on(display_on),
    .i_vsync(vsync), .i_enable(enable), .i_bmp_bit(bmp_bit), .o_anim_state(b_anim),
    .o_direction(b_dir), .o_bmp_y(b_by), .o_bmp_x(b_bx), .o_ghost_x(b_gx), .o_ghost_y(b_gy),
    .o_pixel(b_pix));

  blinky_sprite_renderer #(.X_MAX(20), .Y_MAX(20)) dut_c (
    .i_clk(clk), .i_reset_n(rst_n), .i_hpos(hpos), .i_vpos(vpos), .i_display_on(display_on),
    .i_vsync(vsync), .i_enable(enable), .i_bmp_bit(bmp_bit), .o_anim_state(c_anim),
    .o_direction(c_dir), .o_bmp_y(c_by), .o_bmp_x(c_bx), .o_ghost_x(c_gx), .o_ghost_y(c_gy),
    .o_pixel(c_pix));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int A_GX = 0, A_GY = 1, A_DIR = 2, A_ANIM = 3, A_PIX = 4, A_BX = 5, A_BY = 6;
  localparam int B_GX = 10, B_GY = 11, B_DIR = 12;
  localparam int C_GX = 20, C_GY = 21, C_DIR = 22, C_ANIM = 23;

  typedef struct {
    int    due;
    int    sel;
    int    exp;
    string name;
  } chk_t;

  chk_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic int get_act(int sel);
    case (sel)
      A_GX:    return int'(a_gx);
      A_GY:    return int'(a_gy);
      A_DIR:   return int'(a_dir);
      A_ANIM:  return int'(a_anim);
      A_PIX:   return int'(a_pix);
      A_BX:    return int'(a_bx);
      A_BY:    return int'(a_by);
      B_GX:    return int'(b_gx);
      B_GY:    return int'(b_gy);
      B_DIR:   return int'(b_dir);
      C_GX:    return int'(c_gx);
      C_GY:    return int'(c_gy);
      C_DIR:   return int'(c_dir);
      C_ANIM:  return int'(c_anim);
      default: return -1;
    endcase
  endfunction

  task automatic expect_at(input int dly, input int sel, input int exp, input string name);
    chk_t c;
    c.due  = cyc + dly;
    c.sel  = sel;
    c.exp  = exp;
    c.name = name;
    q.push_back(c);
  endtask

  // monitor: pops every entry whose sample cycle has come, on the falling edge
  always @(negedge clk) begin
    int i;
    int act;
    i = 0;
    while (i < q.size()) begin
      if (q[i].due <= cyc) begin
        act = get_act(q[i].sel);
        n_chk++;
        if (act == q[i].exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", q[i].name, act, q[i].exp, cyc);
        q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n);
    for (int k = 0; k < n; k++) begin
      step(); vsync = 1'b1;
      step(); step(); vsync = 1'b0;
      step();
    end
  endtask

  task automatic pulse_check(input int sel, input int pre, input int post, input string name);
    step(); vsync = 1'b1;
    expect_at(0, sel, pre, {name, "_pre"});
    expect_at(1, sel, post, {name, "_post"});
    step(); step(); vsync = 1'b0;
    step();
  endtask

  task automatic check_reset_vals(input string tag);
    expect_at(0, A_GX, 16, {tag, "_gx"});
    expect_at(0, A_GY, 16, {tag, "_gy"});
    expect_at(0, A_DIR, 0, {tag, "_dir"});
    expect_at(0, A_ANIM, 0, {tag, "_anim"});
    expect_at(0, A_PIX, 0, {tag, "_pix"});
    expect_at(0, C_GX, 16, {tag, "_c_gx"});
  endtask

  initial begin
    int inw;
    repeat (3) step();
    check_reset_vals("rst0");
    step(); rst_n = 1'b1; enable = 1'b1;
    step();

    pulse_check(A_GX, 16, 17, "right_t1");
    pulse_check(A_GX, 17, 18, "right_t2");
    pulse_check(A_GX, 18, 19, "right_t3");
    step();
    expect_at(0, A_GX, 19, "right3_gx");
    expect_at(0, A_GY, 16, "right3_gy");
    expect_at(0, A_DIR, 0, "right3_dir");
    expect_at(0, B_GX, 18, "corner_gx");
    expect_at(0, B_DIR, 1, "corner_dir");
    expect_at(0, B_GY, 16, "corner_gy");
    pulse_check(B_GY, 16, 17, "corner_down");
    step();
    expect_at(0, B_DIR, 1, "corner_down_dir");
    expect_at(0, A_GX, 20, "right4_gx");

    pulse(3);
    step();
    expect_at(0, A_ANIM, 0, "anim_t7");
    pulse_check(A_ANIM, 0, 1, "anim_t8");
    step();
    expect_at(0, A_GX, 24, "t8_gx");
    expect_at(0, C_ANIM, 1, "t8_c_anim");
    expect_at(0, C_GY, 19, "t8_c_gy");
    expect_at(0, C_DIR, 1, "t8_c_dir");

    enable = 1'b0;
    pulse(8);
    step();
    expect_at(0, A_ANIM, 1, "freeze_anim");
    expect_at(0, A_GX, 24, "freeze_gx");
    expect_at(0, C_GY, 19, "freeze_c_gy");

    enable = 1'b1;
    pulse(12);
    step();
    expect_at(0, C_GX, 16, "lap_gx");
    expect_at(0, C_GY, 16, "lap_gy");
    expect_at(0, C_DIR, 0, "lap_dir");
    expect_at(0, A_GX, 36, "t20_gx");
    expect_at(0, A_ANIM, 0, "t20_anim");
    expect_at(0, B_GX, 18, "b_t20_gx");
    expect_at(0, B_GY, 17, "b_t20_gy");
    expect_at(0, B_DIR, 1, "b_t20_dir");

    // mid-run reset with vsync high across release: no tick may be seen
    step(); rst_n = 1'b0; vsync = 1'b1;
    check_reset_vals("rst_mid");
    step(); step(); rst_n = 1'b1;
    step(); step(); step();
    expect_at(0, A_GX, 16, "release_vsync_hi_gx");
    expect_at(0, A_DIR, 0, "release_vsync_hi_dir");
    vsync = 1'b0;
    step();

    bmp_bit = 1'b1; vpos = 9'd20; display_on = 1'b1;
    for (int h = 14; h <= 33; h++) begin
      step(); hpos = 9'(h);
      inw = (h >= 16 && h <= 31) ? 1 : 0;
      expect_at(1, A_BX, inw != 0 ? h - 16 : 0, $sformatf("sweep_bx_h%0d", h));
      expect_at(1, A_BY, inw != 0 ? 4 : 0, $sformatf("sweep_by_h%0d", h));
      expect_at(2, A_PIX, inw, $sformatf("sweep_pix_h%0d", h));
    end

    for (int h = 14; h <= 33; h++) begin
      step(); hpos = 9'(h); display_on = 1'b0;
      expect_at(1, A_BX, 0, $sformatf("blank_bx_h%0d", h));
      expect_at(2, A_PIX, 0, $sformatf("blank_pix_h%0d", h));
    end

    step(); display_on = 1'b1; hpos = 9'd20; vpos = 9'd31;
    expect_at(1, A_BY, 15, "vpos31_by");
    expect_at(2, A_PIX, 1, "vpos31_pix");
    step(); vpos = 9'd32;
    expect_at(1, A_BY, 0, "vpos32_by");
    expect_at(2, A_PIX, 0, "vpos32_pix");
    step(); vpos = 9'd15;
    expect_at(2, A_PIX, 0, "vpos15_pix");

    step(); step(); vpos = 9'd20; bmp_bit = 1'b0;
    for (int h = 16; h <= 19; h++) begin
      step(); hpos = 9'(h);
      expect_at(1, A_BX, h - 16, $sformatf("rom0_bx_h%0d", h));
      expect_at(2, A_PIX, 0, $sformatf("rom0_pix_h%0d", h));
    end

    repeat (6) step();
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d pending checks expected 0", q.size());
      n_chk += q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
